// File: rtl/traffic_phase_sequencer.sv
// traffic_phase_sequencer: demand-actuated N-phase junction controller
// with round-robin service, green extension and emergency pre-emption.
module traffic_phase_sequencer #(
  parameter int N_PHASE   = 4,
  parameter int PHASE_W   = 2,
  parameter int CNT_W     = 8,
  parameter int TICK_DIV  = 1,
  parameter int GREEN_MIN = 3,
  parameter int GREEN_MAX = 6,
  parameter int YELLOW_T  = 2,
  parameter int ALLRED_T  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_PHASE-1:0]   veh_req,
  input  logic                 emerg_req,
  input  logic [PHASE_W-1:0]   emerg_phase,
  output logic [3*N_PHASE-1:0] light,
  output logic [PHASE_W-1:0]   phase,
  output logic [1:0]           state,
  output logic [CNT_W-1:0]     count,
  output logic [N_PHASE-1:0]   req_pending,
  output logic                 emerg_active,
  output logic                 tick
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [1:0] {
    S_GREEN  = 2'd0,
    S_YELLOW = 2'd1,
    S_ALLRED = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [PHASE_W-1:0] phase_q, phase_d;
  logic [PHASE_W-1:0] nxt_q, nxt_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [PW-1:0]      presc_q, presc_d;
  logic [N_PHASE-1:0] req_q, req_d;

  logic [N_PHASE-1:0] ph_oh, en_oh;
  logic [PHASE_W-1:0] ph_inc, rr_nxt, enter;
  logic [CNT_W-1:0]   cnt_inc;
  logic               rr_hit, veh_cur, other_dem;
  logic               hold, preempt, green_exit;
  logic               st_g, st_y, st_r;
  int                 rr_idx;

  assign tick = (presc_q == PW'(TICK_DIV - 1));
  assign emerg_active = emerg_req &&
    ({1'b0, emerg_phase} < (PHASE_W + 1)'(N_PHASE));

  assign st_g = (state_q == S_GREEN);
  assign st_y = (state_q == S_YELLOW);
  assign st_r = (state_q == S_ALLRED);

  assign ph_oh     = N_PHASE'(1) << phase_q;
  assign veh_cur   = |(veh_req & ph_oh);
  assign other_dem = |(req_q & ~ph_oh);
  assign ph_inc    = (phase_q == PHASE_W'(N_PHASE - 1)) ?
                     '0 : phase_q + PHASE_W'(1);
  assign enter     = emerg_active ? emerg_phase : nxt_q;
  assign en_oh     = N_PHASE'(1) << enter;
  assign cnt_inc   = (count_q == {CNT_W{1'b1}}) ?
                     count_q : count_q + CNT_W'(1);

  assign hold    = emerg_active && (phase_q == emerg_phase);
  assign preempt = st_g && emerg_active && !hold;
  assign green_exit = other_dem && !hold &&
    ((count_q >= CNT_W'(GREEN_MIN - 1) && !veh_cur) ||
     count_q >= CNT_W'(GREEN_MAX - 1));

  // First pending phase cyclically after the current one
  always_comb begin
    rr_nxt = ph_inc;
    rr_hit = 1'b0;
    rr_idx = 0;
    for (int k = 1; k < N_PHASE; k++) begin
      rr_idx = (int'(phase_q) + k) % N_PHASE;
      if (!rr_hit && |(req_q & (N_PHASE'(1) << rr_idx))) begin
        rr_nxt = PHASE_W'(rr_idx);
        rr_hit = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    nxt_d   = nxt_q;
    count_d = count_q;
    presc_d = tick ? '0 : presc_q + PW'(1);
    req_d   = req_q | veh_req;
    if (st_g) req_d = req_d & ~ph_oh;
    if (preempt) begin
      state_d = S_YELLOW;
      count_d = '0;
      presc_d = '0;
      nxt_d   = emerg_phase;
    end else if (tick) begin
      unique case (1'b1)
        st_g: begin
          if (green_exit) begin
            state_d = S_YELLOW;
            count_d = '0;
            nxt_d   = emerg_active ? emerg_phase : rr_nxt;
          end else begin
            count_d = cnt_inc;
          end
        end
        st_y: begin
          if (count_q == CNT_W'(YELLOW_T - 1)) begin
            state_d = S_ALLRED;
            count_d = '0;
          end else begin
            count_d = cnt_inc;
          end
        end
        st_r: begin
          if (count_q == CNT_W'(ALLRED_T - 1)) begin
            state_d = S_GREEN;
            count_d = '0;
            phase_d = enter;
            req_d   = req_d & ~en_oh;
          end else begin
            count_d = cnt_inc;
          end
        end
        default: begin
          state_d = S_ALLRED;
          count_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_ALLRED;
      phase_q <= PHASE_W'(N_PHASE - 1);
      nxt_q   <= '0;
      count_q <= '0;
      presc_q <= '0;
      req_q   <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      nxt_q   <= nxt_d;
      count_q <= count_d;
      presc_q <= presc_d;
      req_q   <= req_d;
    end
  end

  always_comb begin
    light = {N_PHASE{3'b100}};
    for (int i = 0; i < N_PHASE; i++) begin
      if (phase_q == PHASE_W'(i)) begin
        if (st_g) light[3*i +: 3] = 3'b001;
        else if (st_y) light[3*i +: 3] = 3'b010;
      end
    end
  end

  assign phase       = phase_q;
  assign state       = state_q;
  assign count       = count_q;
  assign req_pending = req_q;

endmodule

// File: tb/tb_traffic_phase_sequencer.sv
// Bench for traffic_phase_sequencer: two instances (tick every cycle and
// every 4th cycle) checked against a rule-level model plus directed literals.
module tb_traffic_phase_sequencer;

  localparam int NP = 4;
  localparam int GMIN = 3;
  localparam int GMAX = 6;
  localparam int YT = 2;
  localparam int AT = 1;

  typedef struct {
    int st;
    int ph;
    int nx;
    int cnt;
    int pre;
    logic [3:0] req;
  } mdl_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] veh = '0;
  logic er = 1'b0;
  logic [2:0] ep = '0;

  logic [11:0] l1, l4;
  logic [2:0]  ph1, ph4;
  logic [1:0]  st1, st4;
  logic [7:0]  cn1, cn4;
  logic [3:0]  rq1, rq4;
  logic        ea1, ea4, tk1, tk4;

  int errors = 0;
  int checks = 0;
  mdl_t m1, m4;

  always #5 clk = ~clk;

  traffic_phase_sequencer #(
    .N_PHASE(4), .PHASE_W(3), .CNT_W(8), .TICK_DIV(1),
    .GREEN_MIN(GMIN), .GREEN_MAX(GMAX), .YELLOW_T(YT), .ALLRED_T(AT)
  ) u_d1 (
    .clk(clk), .rst(rst), .veh_req(veh), .emerg_req(er),
    .emerg_phase(ep), .light(l1), .phase(ph1), .state(st1),
    .count(cn1), .req_pending(rq1), .emerg_active(ea1), .tick(tk1)
  );

  traffic_phase_sequencer #(
    .N_PHASE(4), .PHASE_W(3), .CNT_W(8), .TICK_DIV(4),
    .GREEN_MIN(GMIN), .GREEN_MAX(GMAX), .YELLOW_T(YT), .ALLRED_T(AT)
  ) u_d4 (
    .clk(clk), .rst(rst), .veh_req(veh), .emerg_req(er),
    .emerg_phase(ep), .light(l4), .phase(ph4), .state(st4),
    .count(cn4), .req_pending(rq4), .emerg_active(ea4), .tick(tk4)
  );

  task automatic check(string nm, int got, int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  function automatic mdl_t mreset();
    mdl_t r;
    r.st = 2; r.ph = NP - 1; r.nx = 0;
    r.cnt = 0; r.pre = 0; r.req = '0;
    return r;
  endfunction

  // All red, then flip the served phase's field by XOR
  function automatic int mlight(mdl_t m);
    logic [11:0] v;
    v = 12'h924;
    if (m.st == 0) v = v ^ (12'(3'b101) << (3 * m.ph));
    if (m.st == 1) v = v ^ (12'(3'b110) << (3 * m.ph));
    return int'(v);
  endfunction

  function automatic mdl_t step(mdl_t m, logic [3:0] vr, logic e,
                                int p, int tdiv);
    mdl_t n;
    logic [3:0] sh;
    bit act, tk, others, own;
    n = m;
    act = e && (p < NP);
    tk = (m.pre == tdiv - 1);
    sh = vr >> m.ph;
    own = sh[0];
    others = |(m.req & ~(4'b1 << m.ph));
    n.req = m.req | vr;
    if (m.st == 0) n.req = n.req & ~(4'b1 << m.ph);
    n.pre = tk ? 0 : m.pre + 1;
    if (m.st == 0 && act && m.ph != p) begin
      n.st = 1; n.cnt = 0; n.pre = 0; n.nx = p;
      return n;
    end
    if (!tk) return n;
    if (m.st == 0) begin
      if (others && !(act && m.ph == p) &&
          ((m.cnt >= GMIN - 1 && !own) || m.cnt >= GMAX - 1)) begin
        n.st = 1; n.cnt = 0;
        if (act) n.nx = p;
        else begin
          n.nx = (m.ph + 1) % NP;
          for (int k = NP - 1; k >= 1; k--) begin
            sh = m.req >> ((m.ph + k) % NP);
            if (sh[0]) n.nx = (m.ph + k) % NP;
          end
        end
      end else n.cnt = (m.cnt < 255) ? m.cnt + 1 : 255;
    end else if (m.st == 1) begin
      if (m.cnt == YT - 1) begin n.st = 2; n.cnt = 0; end
      else n.cnt = m.cnt + 1;
    end else begin
      if (m.cnt == AT - 1) begin
        n.st = 0; n.cnt = 0;
        n.ph = act ? p : m.nx;
        n.req = n.req & ~(4'b1 << n.ph);
      end else n.cnt = m.cnt + 1;
    end
    return n;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m1 <= mreset();
      m4 <= mreset();
    end else begin
      m1 <= step(m1, veh, er, int'(ep), 1);
      m4 <= step(m4, veh, er, int'(ep), 4);
    end
  end

  task automatic cmp(string t, mdl_t m, int tdiv, logic [11:0] l,
                     logic [2:0] ph, logic [1:0] st, logic [7:0] cn,
                     logic [3:0] rq, logic ea, logic tk);
    int nonred;
    logic [11:0] v;
    nonred = 0;
    v = l;
    for (int i = 0; i < NP; i++) begin
      if (v[2:0] != 3'b100) nonred++;
      v = v >> 3;
    end
    check({t, ".light"}, int'(l), mlight(m));
    check({t, ".state"}, int'(st), m.st);
    check({t, ".phase"}, int'(ph), m.ph);
    check({t, ".count"}, int'(cn), m.cnt);
    check({t, ".req"}, int'(rq), int'(m.req));
    check({t, ".emerg"}, int'(ea), int'(er && ep < 3'(NP)));
    check({t, ".tick"}, int'(tk), int'(m.pre == tdiv - 1));
    check({t, ".onegreen"}, int'(nonred <= 1), 1);
  endtask

  always @(negedge clk) begin
    cmp("d1", m1, 1, l1, ph1, st1, cn1, rq1, ea1, tk1);
    cmp("d4", m4, 4, l4, ph4, st4, cn4, rq4, ea4, tk4);
  end

  task automatic cyc(int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    bit found;
    cyc(3);
    check("rst_state", int'(st1), 2);
    check("rst_phase", int'(ph1), 3);
    check("rst_light", int'(l1), 'h924);
    check("rst_tick1", int'(tk1), 1);
    check("rst_tick4", int'(tk4), 0);
    rst = 1'b0;
    cyc(1);
    check("idle_state", int'(st1), 0);
    check("idle_phase", int'(ph1), 0);
    check("idle_light", int'(l1), 'h921);
    cyc(260);
    check("idle_sat", int'(cn1), 255);
    check("idle_hold", int'(st1), 0);

    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    cyc(1);
    check("max_entry", int'(cn1), 0);
    veh = 4'b0101;
    cyc(1);
    veh = 4'b0001;
    cyc(4);
    check("max_g5_state", int'(st1), 0);
    check("max_g5_cnt", int'(cn1), 5);
    cyc(1);
    check("max_yel", int'(st1), 1);
    cyc(2);
    check("max_ar", int'(st1), 2);
    cyc(1);
    check("max_ph2", int'(ph1), 2);
    check("max_g", int'(st1), 0);
    check("max_req", int'(rq1), 1);

    veh = 4'b0000;
    cyc(2);
    check("gap2_cnt", int'(cn1), 2);
    cyc(1);
    check("gap2_yel", int'(st1), 1);
    cyc(3);
    check("gap2_ph0", int'(ph1), 0);
    check("gap2_req", int'(rq1), 0);

    veh = 4'b0010;
    cyc(1);
    veh = 4'b0000;
    cyc(1);
    check("gap0_g2", int'(st1), 0);
    cyc(1);
    check("gap0_yel", int'(st1), 1);
    cyc(3);
    check("gap0_ph1", int'(ph1), 1);

    veh = 4'b1000;
    cyc(1);
    veh = 4'b0000;
    cyc(5);
    check("wrap_ph3", int'(ph1), 3);
    veh = 4'b0101;
    cyc(1);
    veh = 4'b0000;
    cyc(5);
    check("wrap_ph0", int'(ph1), 0);
    check("wrap_req", int'(rq1), 4);
    cyc(6);
    check("wrap_ph2", int'(ph1), 2);

    veh = 4'b0010;
    cyc(1);
    veh = 4'b0000;
    cyc(5);
    check("em_ph1", int'(ph1), 1);
    check("em_cnt0", int'(cn1), 0);
    er = 1'b1;
    ep = 3'd3;
    #1;
    check("em_active", int'(ea1), 1);
    cyc(1);
    check("em_preempt", int'(st1), 1);
    cyc(3);
    check("em_ph3", int'(ph1), 3);
    veh = 4'b0001;
    cyc(1);
    veh = 4'b0000;
    cyc(9);
    check("em_hold", int'(st1), 0);
    check("em_hold_cnt", int'(cn1), 10);
    er = 1'b0;
    cyc(1);
    check("em_release", int'(st1), 1);
    cyc(3);
    check("em_next", int'(ph1), 0);

    er = 1'b1;
    ep = 3'd5;
    #1;
    check("inv_active", int'(ea1), 0);
    cyc(5);
    check("inv_state", int'(st1), 0);
    check("inv_phase", int'(ph1), 0);
    er = 1'b0;

    veh = 4'b1111;
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      if (m4.st == 1) found = 1'b1;
      else cyc(1);
    end
    check("d4_yellow", int'(found), 1);
    rst = 1'b1;
    veh = 4'b0000;
    #1;
    check("mid_light", int'(l4), 'h924);
    check("mid_state", int'(st4), 2);
    check("mid_count", int'(cn4), 0);
    check("mid_req", int'(rq4), 0);
    cyc(1);
    rst = 1'b0;
    cyc(3);
    check("mid_wait", int'(st4), 2);
    cyc(1);
    check("mid_green", int'(st4), 0);
    check("mid_ph0", int'(ph4), 0);
    cyc(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
